wash_cycle_ctrl: RTL and testbench

Sequencer for the washing-machine phase timer. It accepts a coin/start request and issues one timer load per phase (fill, wash, rinse, spin, with an optional second wash+rinse). It pauses the timer while the lid is open and advances on the timer's finish pulse. A per-phase watchdog forces a latched fault if the timer never finishes. It sits between the front-panel inputs and the timer block.

---
 rtl/wash_cycle_ctrl_if.sv | 26 ++
 rtl/wash_cycle_ctrl.sv | 134 +++++++++++++
 tb/tb_wash_cycle_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wash_cycle_ctrl_if.sv
// Front-panel and timer-side signals of the washing-machine phase sequencer.
// The master drives the panel/timer inputs; the slave is the sequencer itself.
interface wash_cycle_ctrl_if;
    logic       coin_in;
    logic       double_wash;
    logic       lid_open;
    logic       timer_done;
    logic       fault_clr;
    logic       timer_load;
    logic [1:0] timer_phase;
    logic       timer_pause;
    logic       busy;
    logic       cycle_done;
    logic       fault;
    logic [2:0] phase_cnt;

    modport master (
        output coin_in, double_wash, lid_open, timer_done, fault_clr,
        input  timer_load, timer_phase, timer_pause, busy, cycle_done, fault, phase_cnt
    );

    modport slave (
        input  coin_in, double_wash, lid_open, timer_done, fault_clr,
        output timer_load, timer_phase, timer_pause, busy, cycle_done, fault, phase_cnt
    );
endinterface

// File: rtl/wash_cycle_ctrl.sv
// Washing-machine phase sequencer: fill, wash, rinse, (wash, rinse,) spin with
// lid pause, a latched done-while-paused flag and a per-phase watchdog fault.
module wash_cycle_ctrl #(
    parameter int unsigned WDOG_W     = 32,
    parameter int unsigned WDOG_LIMIT = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    wash_cycle_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RUN, S_PAUSE, S_DONE, S_FAULT
    } state_e;

    localparam logic [1:0]        PH_FILL   = 2'b00;
    localparam logic [1:0]        PH_WASH   = 2'b01;
    localparam logic [1:0]        PH_RINSE  = 2'b10;
    localparam logic [1:0]        PH_SPIN   = 2'b11;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_LIMIT - 1);

    state_e            state_q, state_d;
    logic [1:0]        phase_q, phase_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              second_q, second_d;
    logic              double_q, double_d;
    logic              pend_q, pend_d;
    logic              coin_q, coin_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              start;

    assign start = bus.coin_in & ~coin_q;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path can infer a latch.
        state_d  = state_q;
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        second_d = second_q;
        double_d = double_q;
        pend_d   = pend_q;
        wdog_d   = wdog_q;
        coin_d   = bus.coin_in;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    double_d = bus.double_wash;
                    phase_d  = PH_FILL;
                    cnt_d    = 3'd0;
                    second_d = 1'b0;
                    pend_d   = 1'b0;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                wdog_d  = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (bus.timer_done || pend_q) begin
                    cnt_d   = cnt_q + 3'd1;
                    pend_d  = 1'b0;
                    state_d = S_LOAD;
                    unique case (phase_q)
                        PH_FILL:  phase_d = PH_WASH;
                        PH_WASH:  phase_d = PH_RINSE;
                        PH_RINSE: begin
                            // The first rinse of a double cycle loops back for a second wash.
                            if (double_q && !second_q) begin
                                phase_d  = PH_WASH;
                                second_d = 1'b1;
                            end else begin
                                phase_d = PH_SPIN;
                            end
                        end
                        PH_SPIN:  state_d = S_DONE;
                    endcase
                end else if (bus.lid_open) begin
                    state_d = S_PAUSE;
                end else if (wdog_q == WDOG_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end
            S_PAUSE: begin
                if (bus.timer_done) pend_d = 1'b1;
                if (!bus.lid_open)  state_d = S_RUN;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_FAULT: begin
                if (bus.fault_clr) begin
                    cnt_d   = 3'd0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            phase_q  <= PH_FILL;
            cnt_q    <= 3'd0;
            second_q <= 1'b0;
            double_q <= 1'b0;
            pend_q   <= 1'b0;
            wdog_q   <= '0;
            // Reads as "already high" so a coin held through reset needs a fresh 0->1 edge.
            coin_q   <= 1'b1;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            state_q  <= state_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            second_q <= second_d;
            double_q <= double_d;
            pend_q   <= pend_d;
            wdog_q   <= wdog_d;
            coin_q   <= coin_d;
        end
    end

    assign bus.timer_load  = (state_q == S_LOAD);
    assign bus.timer_phase = phase_q;
    assign bus.timer_pause = (state_q == S_PAUSE) || (state_q == S_FAULT);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.cycle_done  = (state_q == S_DONE);
    assign bus.fault       = (state_q == S_FAULT);
    assign bus.phase_cnt   = cnt_q;
endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Scoreboard bench for wash_cycle_ctrl: expected load phases and final phase
// counts are queued at stimulus time and popped by a separate monitor.
module tb_wash_cycle_ctrl;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    logic [1:0] exp_phase[$];
    logic [2:0] exp_cnt[$];

    wash_cycle_ctrl_if bif();

    wash_cycle_ctrl #(.WDOG_W(32), .WDOG_LIMIT(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_load();
        for (int i = 0; i < 20; i++) begin
            if (bif.timer_load === 1'b1) break;
            tick();
        end
        check("wait_load", 32'(bif.timer_load), 1);
    endtask

    task automatic finish_phase();
        repeat (5) tick();
        bif.timer_done = 1'b1;
        tick();
        bif.timer_done = 1'b0;
    endtask

    task automatic push_single();
        exp_phase.push_back(2'd0);
        exp_phase.push_back(2'd1);
        exp_phase.push_back(2'd2);
        exp_phase.push_back(2'd3);
        exp_cnt.push_back(3'd4);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_load"},  32'(bif.timer_load),  0);
        check({tag, "_phase"}, 32'(bif.timer_phase), 0);
        check({tag, "_pause"}, 32'(bif.timer_pause), 0);
        check({tag, "_busy"},  32'(bif.busy),        0);
        check({tag, "_done"},  32'(bif.cycle_done),  0);
        check({tag, "_fault"}, 32'(bif.fault),       0);
        check({tag, "_cnt"},   32'(bif.phase_cnt),   0);
    endtask

    // Monitor: every timer_load must match the next queued phase, every
    // cycle_done the next queued completed-phase count.
    initial begin
        forever begin
            @(negedge clk);
            if (bif.timer_load === 1'b1) begin
                if (exp_phase.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_load: got phase %0d expected no load at %0t", bif.timer_phase, $time);
                end else begin
                    check("load_phase", 32'(bif.timer_phase), 32'(exp_phase.pop_front()));
                end
            end
            if (bif.cycle_done === 1'b1) begin
                if (exp_cnt.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_cycle_done: got cnt %0d expected no pulse at %0t", bif.phase_cnt, $time);
                end else begin
                    check("done_phase_cnt", 32'(bif.phase_cnt), 32'(exp_cnt.pop_front()));
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        bif.coin_in     = 1'b0;
        bif.double_wash = 1'b0;
        bif.lid_open    = 1'b0;
        bif.timer_done  = 1'b0;
        bif.fault_clr   = 1'b0;
        repeat (2) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Single cycle: fill, wash, rinse, spin.
        push_single();
        bif.coin_in = 1'b1;
        tick();
        check("start_latency", 32'(bif.timer_load), 1);
        repeat (4) begin
            wait_load();
            finish_phase();
        end
        check("single_done_pulse", 32'(bif.cycle_done), 1);
        check("single_cnt", 32'(bif.phase_cnt), 4);
        tick();
        check("single_busy_low", 32'(bif.busy), 0);
        check("single_done_one_cycle", 32'(bif.cycle_done), 0);
        check("single_phase_hold", 32'(bif.timer_phase), 3);
        repeat (3) tick();
        check("held_coin_no_restart", 32'(bif.busy), 0);
        bif.coin_in = 1'b0;
        tick();

        // Double wash: fill, wash, rinse, wash, rinse, spin.
        exp_phase.push_back(2'd0);
        exp_phase.push_back(2'd1);
        exp_phase.push_back(2'd2);
        exp_phase.push_back(2'd1);
        exp_phase.push_back(2'd2);
        exp_phase.push_back(2'd3);
        exp_cnt.push_back(3'd6);
        bif.coin_in     = 1'b1;
        bif.double_wash = 1'b1;
        tick();
        bif.double_wash = 1'b0;
        repeat (6) begin
            wait_load();
            finish_phase();
        end
        check("double_done_pulse", 32'(bif.cycle_done), 1);
        check("double_cnt", 32'(bif.phase_cnt), 6);
        tick();
        check("double_busy_low", 32'(bif.busy), 0);
        bif.coin_in = 1'b0;
        tick();

        // Lid opened mid-wash with timer_done arriving during the pause.
        push_single();
        bif.coin_in = 1'b1;
        tick();
        bif.coin_in = 1'b0;
        wait_load();
        finish_phase();
        wait_load();
        repeat (2) tick();
        bif.lid_open = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            check("pause_held", 32'(bif.timer_pause), 1);
            check("pause_no_advance", 32'(bif.timer_load), 0);
            check("pause_phase", 32'(bif.timer_phase), 1);
            bif.timer_done = (i == 3);
            tick();
        end
        bif.timer_done = 1'b0;
        bif.lid_open   = 1'b0;
        tick();
        check("resume_pause_low", 32'(bif.timer_pause), 0);
        check("resume_run_no_load", 32'(bif.timer_load), 0);
        tick();
        check("resume_adv_load", 32'(bif.timer_load), 1);
        check("resume_adv_cnt", 32'(bif.phase_cnt), 2);
        finish_phase();
        wait_load();
        finish_phase();
        check("pause_cycle_done", 32'(bif.cycle_done), 1);
        tick();

        // Watchdog: no timer_done in fill, limit of 8 RUN cycles.
        exp_phase.push_back(2'd0);
        bif.coin_in = 1'b1;
        tick();
        bif.coin_in = 1'b0;
        check("wdog_load", 32'(bif.timer_load), 1);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("wdog_not_yet", 32'(bif.fault), 0);
        end
        tick();
        check("wdog_fault", 32'(bif.fault), 1);
        check("wdog_fault_pause", 32'(bif.timer_pause), 1);
        check("wdog_fault_busy", 32'(bif.busy), 1);
        bif.coin_in    = 1'b1;
        bif.timer_done = 1'b1;
        bif.lid_open   = 1'b1;
        tick();
        bif.coin_in    = 1'b0;
        bif.timer_done = 1'b0;
        bif.lid_open   = 1'b0;
        tick();
        check("fault_ignores_inputs", 32'(bif.fault), 1);
        check("fault_no_load", 32'(bif.timer_load), 0);
        bif.fault_clr = 1'b1;
        tick();
        bif.fault_clr = 1'b0;
        check("fault_clr_fault", 32'(bif.fault), 0);
        check("fault_clr_busy", 32'(bif.busy), 0);
        check("fault_clr_cnt", 32'(bif.phase_cnt), 0);
        check("fault_clr_pause", 32'(bif.timer_pause), 0);
        tick();

        // Coin held high through reset release, then toggled while busy.
        bif.coin_in = 1'b1;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("coin_held_reset_busy", 32'(bif.busy), 0);
        check("coin_held_reset_load", 32'(bif.timer_load), 0);
        bif.coin_in = 1'b0;
        tick();
        push_single();
        bif.coin_in = 1'b1;
        tick();
        check("fresh_edge_load", 32'(bif.timer_load), 1);
        for (int k = 0; k < 4; k++) begin
            wait_load();
            bif.coin_in = k[0];
            finish_phase();
        end
        check("toggle_done_pulse", 32'(bif.cycle_done), 1);
        tick();
        repeat (2) tick();
        check("toggle_idle_busy", 32'(bif.busy), 0);
        bif.coin_in = 1'b0;
        tick();

        // Reset while paused in rinse.
        exp_phase.push_back(2'd0);
        exp_phase.push_back(2'd1);
        exp_phase.push_back(2'd2);
        bif.coin_in = 1'b1;
        tick();
        bif.coin_in = 1'b0;
        wait_load();
        finish_phase();
        wait_load();
        finish_phase();
        wait_load();
        tick();
        bif.lid_open = 1'b1;
        tick();
        check("rinse_paused", 32'(bif.timer_pause), 1);
        rst_n = 1'b0;
        tick();
        check_all_zero("mid_reset");
        rst_n = 1'b1;
        bif.lid_open = 1'b0;
        repeat (3) tick();
        check("post_reset_idle", 32'(bif.busy), 0);

        check("exp_phase_drained", 32'(exp_phase.size()), 0);
        check("exp_cnt_drained", 32'(exp_cnt.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
